// File: rtl/bram_checker_if.sv
// BRAM port-A bus between the self-test sequencer (master) and the block RAM (slave).
interface bram_checker_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) ();
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [DATA_W-1:0] douta;

  modport master (output wea, addra, dina, input douta);
  modport slave  (input wea, addra, dina, output douta);
endinterface

// File: rtl/bram_checker.sv
// BRAM self-test sequencer: writes an address-derived pattern, reads it back, reports results.
// Optional FILL phase is built only when CHECKER_FILL_EN is defined; otherwise existing contents are checked.
module bram_checker #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  SEED         = 8'hA5,
  parameter logic [7:0]  MUL          = 8'h1D
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  bram_checker_if.master      bram,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [7:0]          leds
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int unsigned DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam int unsigned PW         = READ_LATENCY * ADDR_W;
  localparam logic [1:0] DRAIN_LAST  = 2'(READ_LATENCY - 1);

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] prod;
    prod = DATA_W'(a) * DATA_W'(MUL);
    return prod + DATA_W'(SEED);
  endfunction

  logic [2:0]              state_q, state_d;
  logic                    start_q;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [1:0]              drain_q, drain_d;
  logic [READ_LATENCY-1:0] pvld_q;
  logic [PW-1:0]           paddr_q;
  logic [ADDR_W:0]         err_q, err_d;
  logic [ADDR_W-1:0]       ferr_q, ferr_d;
  logic                    pass_q, pass_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [7:0]              leds_q, leds_d;
  logic [ADDR_W-1:0]       slot_addr;
  logic                    mismatch;

  // Oldest pipeline slot lines up with the douta word for the address it carries.
  assign slot_addr = paddr_q[PW-1 -: ADDR_W];
  assign mismatch  = pvld_q[READ_LATENCY-1] && (bram.douta != pattern(slot_addr));

`ifdef CHECKER_FILL_EN
  logic              wea_q, wea_d;
  logic [DATA_W-1:0] dina_q, dina_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wea_q  <= 1'b0;
      dina_q <= '0;
    end else begin
      wea_q  <= wea_d;
      dina_q <= dina_d;
    end
  end

  assign bram.wea  = wea_q;
  assign bram.dina = dina_q;
`else
  assign bram.wea  = 1'b0;
  assign bram.dina = '0;
`endif

  assign bram.addra     = addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign leds           = leds_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    pass_d  = pass_q;
`ifdef CHECKER_FILL_EN
    wea_d   = 1'b0;
    dina_d  = dina_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_q) begin
          err_d  = '0;
          ferr_d = '0;
          pass_d = 1'b0;
          addr_d = '0;
`ifdef CHECKER_FILL_EN
          state_d = S_FILL;
          wea_d   = 1'b1;
          dina_d  = pattern('0);
`else
          state_d = S_READ;
`endif
        end
      end
`ifdef CHECKER_FILL_EN
      S_FILL: begin
        if (addr_q == LAST) begin
          state_d = S_READ;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          wea_d  = 1'b1;
          dina_d = pattern(addr_d);
        end
      end
`endif
      S_READ: begin
        if (addr_q == LAST) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else                       drain_d = drain_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (mismatch) begin
      err_d = err_q + 1'b1;
      if (err_q == '0) ferr_d = slot_addr;
    end
    // The final compare lands on the DONE-entry edge, so pass is judged on err_d.
    if (state_d == S_DONE && state_q != S_DONE) pass_d = (err_d == '0);

    busy_d = state_d inside {S_FILL, S_READ, S_DRAIN};
    done_d = (state_d == S_DONE);
    case (state_d)
      S_IDLE:  leds_d = '0;
      S_DONE:  leds_d = {pass_d, ~pass_d, 1'b0, 5'(err_d)};
      default: leds_d = {1'b0, 7'(addr_d)};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      addr_q  <= '0;
      drain_q <= '0;
      pvld_q  <= '0;
      paddr_q <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      // Only a start seen while idle or done is kept; one coinciding with DONE entry is dropped.
      start_q <= start && (state_q == S_IDLE || state_q == S_DONE);
      addr_q  <= addr_d;
      drain_q <= drain_d;
      pvld_q  <= READ_LATENCY'({pvld_q, (state_q == S_READ)});
      paddr_q <= PW'({paddr_q, addr_q});
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      leds_q  <= leds_d;
    end
  end

endmodule

// File: tb/tb_bram_checker.sv
// Bench for bram_checker: behavioural BRAMs (latency 1 and 2) with read-corruption masks, scoreboarded results.
module tb_bram_checker;

`ifdef CHECKER_FILL_EN
  localparam bit FILL = 1'b1;
  localparam int D1   = 34;
  localparam int D2   = 35;
  localparam int COLL = 20;
`else
  localparam bit FILL = 1'b0;
  localparam int D1   = 18;
  localparam int D2   = 19;
  localparam int COLL = 10;
`endif

  logic clk, rst_n, start;
  logic busy1, done1, pass1, busy2, done2, pass2;
  logic [4:0] err1, err2;
  logic [3:0] ferr1, ferr2;
  logic [7:0] leds1, leds2;

  bram_checker_if #(.ADDR_W(4), .DATA_W(8)) b1 ();
  bram_checker_if #(.ADDR_W(4), .DATA_W(8)) b2 ();

  bram_checker #(.ADDR_W(4), .DATA_W(8), .READ_LATENCY(1), .SEED(8'hA5), .MUL(8'h1D)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start), .bram(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_addr(ferr1), .leds(leds1));

  bram_checker #(.ADDR_W(4), .DATA_W(8), .READ_LATENCY(2), .SEED(8'hA5), .MUL(8'h1D)) u_dut2 (
    .clk(clk), .reset(rst_n), .start(start), .bram(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_addr(ferr2), .leds(leds2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 29 + 165) % 256);
  endfunction

  bit bad1 [16];
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];

  // 1-cycle BRAM; reads are corrupted where bad1 is set
  initial begin : model1
    logic [7:0] rd;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = FILL ? 8'h00 : pat(i);
      bad1[i] = 1'b0;
    end
    b1.douta = '0;
    forever begin
      @(posedge clk);
      rd = mem1[b1.addra] ^ (bad1[b1.addra] ? 8'h5A : 8'h00);
      if (b1.wea) mem1[b1.addra] = b1.dina;
      b1.douta <= rd;
    end
  end

  // 2-cycle BRAM, always clean
  initial begin : model2
    logic [7:0] rd, s1;
    for (int i = 0; i < 16; i++) mem2[i] = FILL ? 8'h00 : pat(i);
    b2.douta = '0;
    s1 = '0;
    forever begin
      @(posedge clk);
      rd = mem2[b2.addra];
      if (b2.wea) mem2[b2.addra] = b2.dina;
      b2.douta <= s1;
      s1 = rd;
    end
  end

  typedef struct {
    int         d1;
    logic [4:0] err;
    logic [3:0] ferr;
    logic       pass;
    logic [7:0] leds;
  } res_t;

  res_t        sb[$];
  logic [11:0] wr_exp[$];
  logic [11:0] wr_obs[$];
  int n_checks = 0;
  int n_fail   = 0;
  int d1_edge, d2_edge, overlap;
  bit busy_e1;

  task automatic push_expected();
    res_t r;
    int e = 0;
    int f = 0;
    for (int a = 15; a >= 0; a--) if (bad1[a]) begin e++; f = a; end
    r.d1 = D1; r.err = 5'(e); r.ferr = 4'(f); r.pass = (e == 0);
    r.leds = {r.pass, ~r.pass, 1'b0, r.err};
    sb.push_back(r);
    wr_exp.delete();
    if (FILL) for (int a = 0; a < 16; a++) wr_exp.push_back({4'(a), pat(a)});
  endtask

  task automatic do_run(input int collide_at);
    d1_edge = -1; d2_edge = -1; overlap = 0; busy_e1 = 1'b0;
    wr_obs.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      start = (k == collide_at);
      if (k == 1) busy_e1 = busy1;
      if (b1.wea) wr_obs.push_back({b1.addra, b1.dina});
      if ((busy1 && done1) || (busy2 && done2)) overlap++;
      if (done1 && d1_edge < 0) d1_edge = k;
      if (done2 && d2_edge < 0) d2_edge = k;
      if (d1_edge >= 0 && d2_edge >= 0) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int wea_seen = 0;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({b1.wea, b1.addra, b1.dina, busy1, done1, pass1, err1, ferr1, leds1} !== '0) begin
      n_fail++; $display("FAIL reset.por outputs: busy=%b done=%b wea=%b addra=%h leds=%h, want all 0", busy1, done1, b1.wea, b1.addra, leds1); end
    rst_n = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({b1.wea, b1.addra, b1.dina, busy1, done1, pass1, err1, ferr1, leds1} !== '0) begin
      n_fail++; $display("FAIL reset.mid dut1: busy=%b wea=%b addra=%h leds=%h, want all 0", busy1, b1.wea, b1.addra, leds1); end
    n_checks++; if ({b2.wea, b2.addra, b2.dina, busy2, done2, pass2, err2, ferr2, leds2} !== '0) begin
      n_fail++; $display("FAIL reset.mid dut2: busy=%b wea=%b addra=%h leds=%h, want all 0", busy2, b2.wea, b2.addra, leds2); end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (b1.wea || b2.wea || busy1 || busy2) wea_seen++;
    end
    n_checks++; if (wea_seen !== 0) begin n_fail++; $display("FAIL reset.idle activity: got %0d active cycles, want 0", wea_seen); end
    n_checks++; if ({done1, done2, leds1} !== '0) begin n_fail++; $display("FAIL reset.idle state: done1=%b done2=%b leds=%h, want 0", done1, done2, leds1); end
  endtask

  task automatic test_clean_run();
    res_t r;
    for (int a = 0; a < 16; a++) bad1[a] = 1'b0;
    push_expected();
    do_run(0);
    r = sb.pop_front();
    n_checks++; if (busy_e1 !== 1'b1) begin n_fail++; $display("FAIL clean.busy_at_E1: got %b want 1", busy_e1); end
    n_checks++; if (d1_edge !== r.d1) begin n_fail++; $display("FAIL clean.done_edge: got E%0d want E%0d", d1_edge, r.d1); end
    n_checks++; if ({err1, ferr1, pass1} !== {r.err, r.ferr, r.pass}) begin
      n_fail++; $display("FAIL clean.result: got err=%0d first=%0d pass=%b want err=%0d first=%0d pass=%b", err1, ferr1, pass1, r.err, r.ferr, r.pass); end
    n_checks++; if (leds1 !== r.leds) begin n_fail++; $display("FAIL clean.leds: got %h want %h", leds1, r.leds); end
    n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL clean.busy_done_overlap: got %0d want 0", overlap); end
    n_checks++; if (wr_obs.size() !== wr_exp.size()) begin n_fail++; $display("FAIL clean.write_count: got %0d want %0d", wr_obs.size(), wr_exp.size()); end
    for (int i = 0; i < wr_obs.size() && i < wr_exp.size(); i++) begin
      n_checks++; if (wr_obs[i] !== wr_exp[i]) begin n_fail++; $display("FAIL clean.write[%0d]: got addr/data %h want %h", i, wr_obs[i], wr_exp[i]); end
    end
    n_checks++; if (d2_edge !== D2 || pass2 !== 1'b1 || err2 !== 5'd0) begin
      n_fail++; $display("FAIL lat2.result: got E%0d pass=%b err=%0d want E%0d pass=1 err=0", d2_edge, pass2, err2, D2); end
  endtask

  task automatic test_fault();
    res_t r;
    bad1[5] = 1'b1; bad1[9] = 1'b1;
    push_expected();
    do_run(0);
    r = sb.pop_front();
    n_checks++; if (d1_edge !== r.d1) begin n_fail++; $display("FAIL fault.done_edge: got E%0d want E%0d", d1_edge, r.d1); end
    n_checks++; if ({err1, ferr1, pass1} !== {r.err, r.ferr, r.pass}) begin
      n_fail++; $display("FAIL fault.result: got err=%0d first=%0d pass=%b want err=%0d first=%0d pass=%b", err1, ferr1, pass1, r.err, r.ferr, r.pass); end
    n_checks++; if (leds1 !== r.leds) begin n_fail++; $display("FAIL fault.leds: got %h want %h", leds1, r.leds); end
    n_checks++; if (pass2 !== 1'b1) begin n_fail++; $display("FAIL fault.lat2_pass: got %b want 1", pass2); end
  endtask

  task automatic test_collision();
    res_t r;
    push_expected();
    do_run(COLL);
    r = sb.pop_front();
    n_checks++; if (d1_edge !== r.d1) begin n_fail++; $display("FAIL collide.done_edge: got E%0d want E%0d", d1_edge, r.d1); end
    n_checks++; if ({err1, ferr1, pass1, leds1} !== {r.err, r.ferr, r.pass, r.leds}) begin
      n_fail++; $display("FAIL collide.result: got err=%0d first=%0d leds=%h want err=%0d first=%0d leds=%h", err1, ferr1, leds1, r.err, r.ferr, r.leds); end
  endtask

  task automatic test_done_edge_start();
    res_t r;
    push_expected();
    do_run(D1 - 1);
    r = sb.pop_front();
    repeat (3) @(negedge clk);
    n_checks++; if ({busy1, done1, busy2, done2} !== 4'b0101) begin
      n_fail++; $display("FAIL done_edge_start.state: got busy1=%b done1=%b busy2=%b done2=%b want 0 1 0 1", busy1, done1, busy2, done2); end
    n_checks++; if ({err1, ferr1, leds1} !== {r.err, r.ferr, r.leds}) begin
      n_fail++; $display("FAIL done_edge_start.result: got err=%0d first=%0d leds=%h want err=%0d first=%0d leds=%h", err1, ferr1, leds1, r.err, r.ferr, r.leds); end
  endtask

  task automatic test_rerun();
    res_t r;
    for (int a = 0; a < 16; a++) bad1[a] = 1'b0;
    push_expected();
    do_run(0);
    r = sb.pop_front();
    n_checks++; if (busy_e1 !== 1'b1) begin n_fail++; $display("FAIL rerun.busy_at_E1: got %b want 1", busy_e1); end
    n_checks++; if (d1_edge !== r.d1) begin n_fail++; $display("FAIL rerun.done_edge: got E%0d want E%0d", d1_edge, r.d1); end
    n_checks++; if ({err1, ferr1, pass1, leds1} !== {r.err, r.ferr, r.pass, r.leds}) begin
      n_fail++; $display("FAIL rerun.result: got err=%0d first=%0d pass=%b leds=%h want err=%0d first=%0d pass=%b leds=%h", err1, ferr1, pass1, leds1, r.err, r.ferr, r.pass, r.leds); end
  endtask

  task automatic test_reset_mid_read();
    res_t r;
    bit hit = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy1 && !b1.wea && b1.addra == 4'd7) begin hit = 1'b1; break; end
    end
    n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_read.reach_addr7: got %b want 1", hit); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({b1.wea, b1.addra, b1.dina, busy1, done1, pass1, err1, ferr1, leds1} !== '0) begin
      n_fail++; $display("FAIL rst_read.outputs: busy=%b addra=%h leds=%h err=%0d, want all 0", busy1, b1.addra, leds1, err1); end
    @(negedge clk); rst_n = 1'b1;
    push_expected();
    do_run(0);
    r = sb.pop_front();
    n_checks++; if (d1_edge !== r.d1 || pass1 !== 1'b1 || leds1 !== r.leds) begin
      n_fail++; $display("FAIL rst_read.rerun: got E%0d pass=%b leds=%h want E%0d pass=1 leds=%h", d1_edge, pass1, leds1, r.d1, r.leds); end
  endtask

  task automatic test_last_addr();
    res_t r;
    bad1[15] = 1'b1;
    push_expected();
    do_run(0);
    r = sb.pop_front();
    n_checks++; if (d1_edge !== r.d1) begin n_fail++; $display("FAIL last_addr.done_edge: got E%0d want E%0d", d1_edge, r.d1); end
    n_checks++; if ({err1, ferr1, pass1, leds1} !== {r.err, r.ferr, r.pass, r.leds}) begin
      n_fail++; $display("FAIL last_addr.result: got err=%0d first=%0d pass=%b leds=%h want err=%0d first=%0d pass=%b leds=%h", err1, ferr1, pass1, leds1, r.err, r.ferr, r.pass, r.leds); end
    n_checks++; if (wr_obs.size() !== wr_exp.size()) begin n_fail++; $display("FAIL last_addr.write_count: got %0d want %0d", wr_obs.size(), wr_exp.size()); end
    bad1[15] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_fault();
    test_collision();
    test_done_edge_start();
    test_rerun();
    test_reset_mid_read();
    test_last_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
